// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide, single-port memory between an instruction
// fetch port and a data port. Sub-word stores become a read cycle followed by
// a merge-and-write cycle, so the memory never needs byte enables.
//
// Handshake: a port raises *_req and holds its request fields stable until it
// sees *_gnt, which is combinational and only asserted in IDLE. A request is
// accepted in the cycle where req && gnt. A load or fetch then returns data
// one cycle later, flagged by a one-cycle *_rvalid. A store reports completion
// with a one-cycle d_wdone. A request dropped before its grant has no effect.
module mem_arbiter #(
  parameter int RR = 1,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_wdone,
  output logic [AW-1:0] mem_A,
  output logic [31:0]   mem_WD,
  output logic          mem_MemWrite,
  input  logic [31:0]   mem_RD
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  // 0: fetch port was granted last, 1: data port was granted last
  logic          rr_last_q, rr_last_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          d_wdone_q, d_wdone_d;
  logic [AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [3:0]    rmw_be_q, rmw_be_d;
  logic [31:0]   rmw_wdata_q, rmw_wdata_d;
  logic          pick_d;
  logic [31:0]   merged;

  // Read data is a straight copy of the memory output; rvalid qualifies it.
  assign i_rdata  = mem_RD;
  assign d_rdata  = mem_RD;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign d_wdone  = d_wdone_q;

  // State, arbitration history, response pulses and the latched partial store.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_wdone_q   <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      d_wdone_q   <= d_wdone_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
    end
  end

  // Byte-lane merge of latched store data over the word read in the previous cycle.
  always_comb begin
    merged = mem_RD;
    for (int n = 0; n < 4; n++) begin
      if (rmw_be_q[n]) merged[8*n +: 8] = rmw_wdata_q[8*n +: 8];
    end
  end

  // Arbitration, memory command and next-state. Everything is held quiet while
  // reset is high so an aborted read-modify-write can never reach the memory.
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    i_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    d_wdone_d    = 1'b0;
    rmw_addr_d   = rmw_addr_q;
    rmw_be_d     = rmw_be_q;
    rmw_wdata_d  = rmw_wdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    mem_A        = '0;
    mem_WD       = '0;
    mem_MemWrite = 1'b0;
    // Data wins when alone, under fixed priority, or when fetch went last.
    pick_d       = d_req && (!i_req || (RR == 0) || !rr_last_q);

    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_d) begin
            d_gnt     = 1'b1;
            rr_last_d = 1'b1;
            mem_A     = d_addr;
            if (d_we) begin
              if (d_be == 4'hF) begin
                mem_WD       = d_wdata;
                mem_MemWrite = 1'b1;
                d_wdone_d    = 1'b1;
              end else if (d_be == 4'h0) begin
                d_wdone_d = 1'b1;
              end else begin
                // Read the old word now, merge and write it next cycle.
                rmw_addr_d  = d_addr;
                rmw_be_d    = d_be;
                rmw_wdata_d = d_wdata;
                state_d     = ST_RMW;
              end
            end else begin
              d_rvalid_d = 1'b1;
            end
          end else if (i_req) begin
            i_gnt      = 1'b1;
            rr_last_d  = 1'b0;
            mem_A      = i_addr;
            i_rvalid_d = 1'b1;
          end
        end
        ST_RMW: begin
          mem_A        = rmw_addr_q;
          mem_WD       = merged;
          mem_MemWrite = 1'b1;
          d_wdone_d    = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance wired to a small
// word memory model, plus a fixed-priority instance sharing the same inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_wdone, mem_MemWrite;
  logic [31:0] i_rdata, d_rdata, mem_A, mem_WD;
  logic [31:0] mem_RD;

  logic        f_i_gnt, f_i_rvalid, f_d_gnt, f_d_rvalid, f_d_wdone, f_mem_MemWrite;
  logic [31:0] f_i_rdata, f_d_rdata, f_mem_A, f_mem_WD;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_arbiter #(.RR(1), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wdone(d_wdone),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_MemWrite(mem_MemWrite), .mem_RD(mem_RD)
  );

  mem_arbiter #(.RR(0), .AW(32)) dut_fp (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(f_i_gnt), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata), .d_wdone(f_d_wdone),
    .mem_A(f_mem_A), .mem_WD(f_mem_WD), .mem_MemWrite(f_mem_MemWrite), .mem_RD(32'h0)
  );

  // word memory: synchronous write, registered read of the old contents
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_MemWrite) mem[mem_A[11:2]] <= mem_WD;
    mem_RD <= mem[mem_A[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    idle_inputs();

    // preloads while reset is held
    preload(10'd4,  32'hDEADBEEF);
    preload(10'd12, 32'hAABBCCDD);
    preload(10'd16, 32'h01020304);

    // reset values
    @(negedge clk); #1;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_wdone", 32'(d_wdone), 32'd0);
    chk("rst_memwrite", 32'(mem_MemWrite), 32'd0);
    chk("rst_mem_a", mem_A, 32'd0);
    chk("rst_mem_wd", mem_WD, 32'd0);

    // conflict: both ports held for four cycles right after reset
    @(negedge clk);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr_gnt_c%0d", c), 32'({i_gnt, d_gnt}), 32'(rr_exp[c]));
      chk($sformatf("rr_mem_a_c%0d", c), mem_A, rr_exp[c][0] ? 32'h200 : 32'h100);
      chk($sformatf("fp_gnt_c%0d", c), 32'({f_i_gnt, f_d_gnt}), 32'b01);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("idle_mem_a", mem_A, 32'd0);
    chk("idle_gnt", 32'({i_gnt, d_gnt}), 32'd0);

    // fetch only
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    chk("f_i_gnt", 32'(i_gnt), 32'd1);
    chk("f_d_gnt", 32'(d_gnt), 32'd0);
    chk("f_mem_a", mem_A, 32'h10);
    chk("f_memwrite", 32'(mem_MemWrite), 32'd0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("f_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f_d_outs", 32'({d_gnt, d_rvalid, d_wdone}), 32'd0);
    @(negedge clk); #1;
    chk("f_i_rvalid_pulse", 32'(i_rvalid), 32'd0);

    // full store followed back-to-back by a load of the same word
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h12345678;
    #1;
    chk("fs_d_gnt", 32'(d_gnt), 32'd1);
    chk("fs_memwrite", 32'(mem_MemWrite), 32'd1);
    chk("fs_mem_wd", mem_WD, 32'h12345678);
    chk("fs_mem_a", mem_A, 32'h20);
    @(negedge clk);
    d_we = 1'b0; d_be = 4'h0; d_wdata = '0;
    #1;
    chk("fs_wdone", 32'(d_wdone), 32'd1);
    chk("ld_d_gnt", 32'(d_gnt), 32'd1);
    chk("ld_memwrite", 32'(mem_MemWrite), 32'd0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("ld_rvalid", 32'(d_rvalid), 32'd1);
    chk("ld_rdata", d_rdata, 32'h12345678);
    chk("fs_wdone_pulse", 32'(d_wdone), 32'd0);

    // partial store, fetch request arriving during the merge cycle
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 32'h30; d_wdata = 32'h11223344;
    #1;
    chk("ps_d_gnt", 32'(d_gnt), 32'd1);
    chk("ps_read_cycle_we", 32'(mem_MemWrite), 32'd0);
    chk("ps_read_mem_a", mem_A, 32'h30);
    @(negedge clk);
    idle_inputs();
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    chk("ps_rmw_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    chk("ps_rmw_we", 32'(mem_MemWrite), 32'd1);
    chk("ps_rmw_mem_a", mem_A, 32'h30);
    chk("ps_rmw_wd", mem_WD, 32'hAA22CC44);
    chk("ps_rmw_wdone", 32'(d_wdone), 32'd0);
    @(negedge clk); #1;
    chk("ps_wdone", 32'(d_wdone), 32'd1);
    chk("ps_i_gnt_after", 32'(i_gnt), 32'd1);
    chk("ps_mem_word", mem[12], 32'hAA22CC44);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("ps_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("ps_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("ps_wdone_pulse", 32'(d_wdone), 32'd0);

    // store with no byte enables
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h30; d_wdata = 32'hFFFFFFFF;
    #1;
    chk("z_d_gnt", 32'(d_gnt), 32'd1);
    chk("z_memwrite", 32'(mem_MemWrite), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("z_wdone", 32'(d_wdone), 32'd1);
    chk("z_memwrite2", 32'(mem_MemWrite), 32'd0);
    chk("z_mem_word", mem[12], 32'hAA22CC44);

    // reset during the merge cycle of a partial store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hAAAAAAAA;
    #1;
    chk("ra_d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("ra_memwrite_in_reset", 32'(mem_MemWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ra_outs", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, d_wdone, mem_MemWrite}), 32'd0);
    chk("ra_mem_a", mem_A, 32'd0);
    chk("ra_mem_wd", mem_WD, 32'd0);
    chk("ra_mem_word", mem[16], 32'h01020304);
    @(negedge clk); #1;
    chk("ra_no_late_wdone", 32'(d_wdone), 32'd0);
    chk("ra_mem_word2", mem[16], 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
